// File: rtl/fetch_pc_sequencer_if.sv
// fetch_pc_sequencer_if: decode-side bus of the fetch PC sequencer (unit flags, redirects, issued PC)
interface fetch_pc_sequencer_if #(
  parameter int PC_WIDTH  = 32,
  parameter int NUM_UNITS = 5
) ();
  logic [NUM_UNITS-1:0] unitEmpty;
  logic                 halt;
  logic [6:0]           operatorType;
  logic                 jump;
  logic [PC_WIDTH-1:0]  jumppc;
  logic                 pcChange;
  logic [PC_WIDTH-1:0]  changeData;
  logic [PC_WIDTH-1:0]  pc;
  logic                 available;
  logic                 decodePulse;
  logic [31:0]          issueCount;
  modport master (
    output unitEmpty, halt, operatorType, jump, jumppc, pcChange, changeData,
    input  pc, available, decodePulse, issueCount
  );
  modport slave (
    input  unitEmpty, halt, operatorType, jump, jumppc, pcChange, changeData,
    output pc, available, decodePulse, issueCount
  );
endinterface

// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer: warm-up delay, gated issue of fetch PCs with prioritised/latched redirects
module fetch_pc_sequencer #(
  parameter int                     PC_WIDTH       = 32,
  parameter int                     NUM_UNITS      = 5,
  parameter logic [PC_WIDTH-1:0]    RESET_PC       = '0,
  parameter logic [PC_WIDTH-1:0]    PC_STEP        = 1,
  parameter int unsigned            STARTUP_CYCLES = 100,
  parameter logic [6:0]             BRANCH_OP      = 7'b1100011
) (
  input logic                  clock,
  input logic                  reset,
  fetch_pc_sequencer_if.slave  bus
);
  typedef enum logic [1:0] {WARMUP, FIRST, RUN} state_e;
  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d, issue_cnt_q, issue_cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, pend_pc_q, pend_pc_d, sel_pc;
  logic                pend_v_q, pend_v_d, pend_chg_q, pend_chg_d;
  logic                avail_q, avail_d, pulse_q, pulse_d;
  logic                br, sel_v, sel_chg, issue;
  // Priority: live pcChange > pending pcChange > live branch > pending branch
  always_comb begin
    br          = bus.operatorType == BRANCH_OP && bus.jump;
    sel_chg     = bus.pcChange || (pend_v_q && pend_chg_q);
    sel_v       = sel_chg || br || pend_v_q;
    sel_pc      = bus.pcChange ? bus.changeData :
                  (pend_v_q && pend_chg_q) ? pend_pc_q :
                  br ? bus.jumppc : pend_pc_q;
    issue       = state_q != WARMUP && (&bus.unitEmpty) && !bus.halt;
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_pc_d   = pend_pc_q;
    pend_chg_d  = pend_chg_q;
    avail_d     = state_q != WARMUP && (&bus.unitEmpty);
    pulse_d     = issue;
    issue_cnt_d = issue_cnt_q + 32'(issue);
    if (state_q == WARMUP) begin
      cnt_d   = cnt_q != 0 ? cnt_q - 32'd1 : cnt_q;
      state_d = cnt_q == 0 ? FIRST : WARMUP;
    end else if (issue) begin
      pc_d     = sel_v ? sel_pc : state_q == FIRST ? RESET_PC : pc_q + PC_STEP;
      state_d  = RUN;
      pend_v_d = 1'b0;
    end else if (sel_v) begin
      pend_v_d   = 1'b1;
      pend_pc_d  = sel_pc;
      pend_chg_d = sel_chg;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= WARMUP;
      cnt_q       <= 32'(STARTUP_CYCLES);
      pc_q        <= RESET_PC;
      pend_v_q    <= 1'b0;
      pend_pc_q   <= '0;
      pend_chg_q  <= 1'b0;
      avail_q     <= 1'b0;
      pulse_q     <= 1'b0;
      issue_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pc_q        <= pc_d;
      pend_v_q    <= pend_v_d;
      pend_pc_q   <= pend_pc_d;
      pend_chg_q  <= pend_chg_d;
      avail_q     <= avail_d;
      pulse_q     <= pulse_d;
      issue_cnt_q <= issue_cnt_d;
    end
  end
  assign bus.pc          = pc_q;
  assign bus.available   = avail_q;
  assign bus.decodePulse = pulse_q;
  assign bus.issueCount  = issue_cnt_q;
endmodule

// File: doc/fetch_pc_sequencer.md
Name: fetch_pc_sequencer

Overview:
Parametrised successor to the front-end PC controller. It generates the fetch PC and a one-cycle decode pulse for the Tomasulo-style core. Issue is gated on a configurable number of functional-unit/ROB empty flags. Adds a programmable warm-up delay, prioritised redirects (commit-time pcChange over branch resolution), redirect latching while stalled, a halt input and an issued-instruction counter.

Parameters:
PC_WIDTH, 32, width of pc, jumppc, changeData
NUM_UNITS, 5, number of unit-empty flags (add, lw, sw, rob, bne by default)
RESET_PC, 0, first address issued after warm-up
PC_STEP, 1, sequential increment (1 = word addressing)
STARTUP_CYCLES, 100, idle cycles after reset before first issue (0 allowed)
BRANCH_OP, 7'b1100011, operatorType value identifying a conditional branch

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high
unitEmpty  in  NUM_UNITS  per-unit empty flags; issue requires all high
halt  in  1  level; while high no issue occurs
operatorType  in  7  opcode of instruction in decode
jump  in  1  branch resolved taken (qualified by operatorType==BRANCH_OP)
jumppc  in  PC_WIDTH  branch target
pcChange  in  1  commit/exception redirect request
changeData  in  PC_WIDTH  redirect target
pc  out  PC_WIDTH  address of instruction currently presented to decode
available  out  1  registered AND of unitEmpty
decodePulse  out  1  one-cycle strobe: pc holds a newly issued address
issueCount  out  32  number of issues since reset, wraps at 2^32

Behaviour:
- Reset (any cycle, including mid-warm-up or mid-redirect): pc=RESET_PC, available=0, decodePulse=0, issueCount=0, pending cleared, state=WARMUP, counter=STARTUP_CYCLES.
- States: WARMUP -> FIRST -> RUN; no path back except reset.
- WARMUP: counter!=0 -> decrement, no outputs change; counter==0 -> go to FIRST next cycle. With STARTUP_CYCLES=N the first pulse cannot appear before cycle N+2 after reset deasserts.
- available <= &unitEmpty every cycle outside WARMUP; held 0 in WARMUP.
- issue condition (FIRST/RUN): &unitEmpty && !halt, sampled on current inputs, not on the registered available.
- Redirect target selection each cycle: pcChange -> changeData; else (operatorType==BRANCH_OP && jump) -> jumppc; else none.
- Issue in FIRST: pc <= (redirect this cycle or pending) ? target : RESET_PC. Then state->RUN.
- Issue in RUN: pc <= redirect/pending target if present, else pc+PC_STEP modulo 2^PC_WIDTH.
- On issue: decodePulse<=1 for exactly one cycle, issueCount++, pending cleared.
- No issue: decodePulse<=0, pc holds. Any redirect this cycle is latched into pendingPc with pendingIsChange flag.
- Pending overwrite rules: a new pcChange always overwrites. A branch redirect overwrites only if pending is empty or pendingIsChange=0. A live pcChange in the issue cycle beats a pending branch. A live branch never beats a pending pcChange.
- Redirects arriving in WARMUP are ignored.
- Back-to-back issues allowed: one pulse per cycle while the issue condition holds. decodePulse is never high two cycles for the same pc value.

Test Plan:
- STARTUP_CYCLES=3, RESET_PC=0x10, all unitEmpty=1 -> no pulse during warm-up; first pulse with pc=0x10, then 0x11, 0x12 on consecutive cycles; issueCount=3.
- Running, one unitEmpty bit low for 4 cycles -> pc frozen, decodePulse=0, available=0 one cycle after the drop; on release pc advances by exactly PC_STEP.
- operatorType=BRANCH_OP, jump=1, jumppc=0x40 while the issue condition holds -> next pc=0x40. Same with jump=0 -> sequential pc+1.
- Stalled; branch to 0x40 at cycle t, pcChange to 0x80 at t+2, stall released at t+5 -> issued pc=0x80. Reverse order (pcChange first, then branch) -> 0x80.
- pc=0xFFFFFFFF, PC_STEP=1, issue -> pc wraps to 0x0; halt=1 for 3 cycles -> no pulses, issueCount unchanged.
- reset asserted mid-stall with pending redirect -> pending discarded; after warm-up the first pc is RESET_PC.
